// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush controller for a 5-stage pipeline. It drives the PC
// write enable, the pipeline latch enables/flushes and the PC redirect. It
// also keeps a pending redirect when a mispredict resolves while the
// instruction fetch is still outstanding.
module pipeline_hazard_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mispredict,
  input  logic [31:0]      ex_target_pc,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1,
    HALT       = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend_pc;
  logic        load_pend;
  logic        load_use;
  logic        dstall;

  // A load in EX whose destination feeds the ID instruction (r0 never hazards).
  assign load_use = ex_is_load && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign dstall   = mem_dreq && !dhit;
  assign state_dbg = state;

  // State and pending-redirect register; a reset drops any pending redirect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      pend_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      if (load_pend) pend_pc <= ex_target_pc;
    end
  end

  // Priority-ordered hazard resolution: halt, dcache freeze, redirects,
  // load-use, icache miss, then the normal all-advance case.
  always_comb begin
    state_nxt    = state;
    load_pend    = 1'b0;
    pc_en        = 1'b1;
    pc_redirect  = 1'b0;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    redirect_pc  = (state == REDIR_PEND) ? pend_pc : ex_target_pc;

    if (RST) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state == HALT) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      halted    = 1'b1;
    end else if (wb_halt) begin
      // Let the halt instruction retire, freeze everything behind it.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      state_nxt = HALT;
    end else if (dstall) begin
      // Whole pipe frozen; a mispredict in EX is re-evaluated once MEM drains.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (state == REDIR_PEND) begin
      // Whatever the fetch returns is wrong-path, so IF/ID is always cleared.
      if_id_flush = 1'b1;
      if (ihit) begin
        pc_redirect = 1'b1;
        state_nxt   = RUN;
      end else begin
        pc_en = 1'b0;
      end
    end else if (ex_mispredict) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (ihit) begin
        pc_redirect = 1'b1;
      end else begin
        pc_en     = 1'b0;
        load_pend = 1'b1;
        state_nxt = REDIR_PEND;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Saturating performance counters: PC-stall cycles and redirect events.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALT) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: directed scenarios followed by random
// traffic, compared each cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_sequencer;

  localparam int CW = 4;  // small counters so saturation is reachable
  localparam int EW = 42; // {10 control bits, redirect_pc}

  logic          CLK = 1'b0;
  logic          RST;
  logic          ihit, dhit, mem_dreq, ex_is_load, id_uses_rt, ex_mispredict, wb_halt;
  logic [4:0]    ex_rt, id_rs, id_rt;
  logic [31:0]   ex_target_pc;
  logic          pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  // Model state.
  logic          m_halted, m_pending;
  logic [31:0]   m_pend_pc;
  logic [CW-1:0] m_stall, m_flush;
  int            halt_len;

  pipeline_hazard_sequencer #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mispredict(ex_mispredict),
    .ex_target_pc(ex_target_pc), .wb_halt(wb_halt), .pc_en(pc_en),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected combinational outputs for the current inputs and model state.
  function automatic logic [EW-1:0] model_eval();
    logic pe, pr, ie, de, me, we, ifl, dfl, mfl, h;
    logic lu;
    logic [31:0] rpc;
    lu  = ex_is_load && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    rpc = m_pending ? m_pend_pc : ex_target_pc;
    {pe, pr, ie, de, me, we, ifl, dfl, mfl, h} = 10'b1011110000;
    if (RST)                    {pe, pr, ie, de, me, we, ifl, dfl, mfl, h} = 10'b0000001110;
    else if (m_halted)          {pe, pr, ie, de, me, we, ifl, dfl, mfl, h} = 10'b0000000001;
    else if (wb_halt)           {pe, pr, ie, de, me, we, ifl, dfl, mfl, h} = 10'b0000010000;
    else if (mem_dreq && !dhit) {pe, pr, ie, de, me, we, ifl, dfl, mfl, h} = 10'b0000000000;
    else if (m_pending)         begin pe = ihit; pr = ihit; ifl = 1'b1; end
    else if (ex_mispredict)     begin pe = ihit; pr = ihit; ifl = 1'b1; dfl = 1'b1; end
    else if (lu)                begin pe = 1'b0; ie = 1'b0; dfl = 1'b1; end
    else if (!ihit)             begin pe = 1'b0; ifl = 1'b1; end
    return {pe, pr, ie, de, me, we, ifl, dfl, mfl, h, rpc};
  endfunction

  // Advance the model across a clock edge given the cycle's expected outputs.
  task automatic model_clock(input logic [EW-1:0] e);
    if (RST) begin
      m_halted = 0; m_pending = 0; m_pend_pc = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (!e[41] && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
      if (e[40] && m_flush != {CW{1'b1}}) m_flush = m_flush + 1'b1;
      if (wb_halt) begin
        m_halted = 1; m_pending = 0;
      end else if (!(mem_dreq && !dhit)) begin
        if (m_pending && ihit) m_pending = 0;
        else if (!m_pending && ex_mispredict && !ihit) begin
          m_pending = 1; m_pend_pc = ex_target_pc;
        end
      end
    end
  endtask

  // One cycle: predict, compare away from the edge, then clock the model.
  task automatic step(input string tag);
    logic [EW-1:0] e;
    exp_q.push_back(model_eval());
    @(negedge CLK);
    e = exp_q.pop_front();
    check({tag, ".ctl"}, 64'({pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                             if_id_flush, id_ex_flush, ex_mem_flush, halted}), 64'(e[41:32]));
    check({tag, ".rpc"}, 64'(redirect_pc), 64'(e[31:0]));
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
    @(posedge CLK);
    model_clock(e);
    #1;
  endtask

  task automatic drive_idle();
    ihit = 1; dhit = 1; mem_dreq = 0; ex_is_load = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    id_uses_rt = 0; ex_mispredict = 0; ex_target_pc = 0; wb_halt = 0;
  endtask

  task automatic drive_random();
    ihit          = ($urandom_range(0, 3) != 0);
    dhit          = ($urandom_range(0, 2) != 0);
    mem_dreq      = ($urandom_range(0, 2) == 0);
    ex_is_load    = $urandom_range(0, 1) == 1;
    ex_rt         = 5'($urandom_range(0, 3));
    id_rs         = 5'($urandom_range(0, 3));
    id_rt         = 5'($urandom_range(0, 3));
    id_uses_rt    = $urandom_range(0, 1) == 1;
    ex_mispredict = ($urandom_range(0, 5) == 0);
    ex_target_pc  = $urandom;
    wb_halt       = ($urandom_range(0, 79) == 0);
    RST           = (halt_len > 4) || ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    m_halted = 0; m_pending = 0; m_pend_pc = 0; m_stall = 0; m_flush = 0; halt_len = 0;
    drive_idle();
    RST = 1;
    @(posedge CLK); #1;

    // Reset held two cycles, then a clean run cycle.
    step("reset0");
    step("reset1");
    RST = 0;
    step("run");

    // Load-use hazard, then the same with r0 as destination.
    ex_is_load = 1; ex_rt = 8; id_rs = 8;
    step("load_use");
    check("load_use.stall1", 64'(stall_cnt), 64'd1);
    ex_rt = 0; id_rs = 0;
    step("load_r0");
    drive_idle();

    // Mispredict with the fetch completing.
    ex_mispredict = 1; ex_target_pc = 32'h40;
    step("mis_hit");
    check("mis_hit.flush1", 64'(flush_cnt), 64'd1);

    // Mispredict during a 3-cycle icache miss.
    ihit = 0; ex_target_pc = 32'h100;
    step("mis_miss0");
    ex_mispredict = 0; ex_target_pc = 32'h0;
    step("pend1");
    step("pend2");
    ihit = 1;
    step("pend_hit");
    check("pend.stall4", 64'(stall_cnt), 64'd4);
    check("pend.flush2", 64'(flush_cnt), 64'd2);

    // Dcache stall masks a mispredict for two cycles.
    mem_dreq = 1; dhit = 0; ex_mispredict = 1; ex_target_pc = 32'h200;
    step("dstall0");
    step("dstall1");
    dhit = 1;
    step("dstall_done");
    check("dstall.stall6", 64'(stall_cnt), 64'd6);
    check("dstall.flush3", 64'(flush_cnt), 64'd3);
    drive_idle();

    // Halt, noise while halted, then reset back to RUN.
    wb_halt = 1;
    step("halt_wb");
    wb_halt = 0;
    for (int i = 0; i < 3; i++) begin
      ihit = $urandom_range(0, 1) == 1; ex_mispredict = 1; ex_target_pc = $urandom;
      step("halted");
    end
    check("halt.stall7", 64'(stall_cnt), 64'd7);
    drive_idle();
    RST = 1;
    step("halt_reset");
    RST = 0;
    step("after_halt");
    check("after_halt.stall0", 64'(stall_cnt), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step("rand");
      halt_len = m_halted ? halt_len + 1 : 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
